uart_pkt_framer: RTL and testbench
==================================

// Module: uart_pkt_framer
// PURPOSE
//  Upstream feeder for the UART transmitter. Buffers one variable-length byte frame from the
//  processing side, then emits it as a framed packet over the transmitter's byte handshake:
//  SOF0, SOF1, LEN, payload[0..LEN-1], CHK.
//  Sits between the sample/packet logic and the serial TX stage.
// PARAMETERS
//  MAX_LEN  64     payload buffer depth in bytes, legal range 1..255
//  SOF0     8'hAA  first header byte
//  SOF1     8'h55  second header byte
// PORTS
//  clk       in   1  clock
//  rst_n     in   1  asynchronous reset, active-low
//  in_data   in   8  payload byte from source
//  in_vld    in   1  in_data valid
//  in_last   in   1  qualifies in_data as last byte of frame
//  in_rdy    out  1  framer accepts a payload byte this cycle
//  tx_data   out  8  byte to serial transmitter
//  tx_vld    out  1  tx_data valid
//  tx_rdy    in   1  transmitter idle, byte taken when tx_vld & tx_rdy
//  busy      out  1  packet transmission in progress (any state but COLLECT)
//  frm_done  out  1  1-cycle pulse after the CHK byte handshake
//  trunc     out  1  1-cycle pulse: frame closed at MAX_LEN without in_last
// BEHAVIOUR
//  Reset values
//  - State=COLLECT; in_rdy, tx_vld, busy, frm_done, trunc=0; tx_data=8'h00; counters and CHK=0.
//  - in_rdy is registered: 1 from the first clk edge after rst_n release while in COLLECT.
//  - Reset mid-packet discards the frame; tx_vld drops asynchronously.
//  Input side
//  - A byte is written when in_vld & in_rdy; it is stored at index wr_cnt, then wr_cnt++.
//  - CHK accumulates sum mod 256 of the payload bytes.
//  - The frame closes on acceptance of a byte that has in_last=1, or that brings wr_cnt to MAX_LEN.
//    - The MAX_LEN case without in_last pulses trunc in the next cycle.
//    - Remaining source bytes wait and become the next frame.
//  - On frame close: in_rdy=0 next cycle; LEN=wr_cnt (1..MAX_LEN); CHK+=LEN.
//  Output handshake
//  - Transfer occurs when tx_vld & tx_rdy.
//  - Once asserted, tx_vld/tx_data hold stable until transfer.
//  - tx_vld is never gated by tx_rdy.
//  - The transmitter accepts in IDLE regardless of its own rdy, so this block's tx_vld & tx_rdy is
//    the only qualifying condition. tx_rdy low in the cycle after a transfer is expected.
//  State machine
//  - COLLECT: in_rdy=1 (registered), tx_vld=0. On frame close -> HDR0.
//  - HDR0: tx_data=SOF0, tx_vld=1. Transfer -> HDR1.
//  - HDR1: tx_data=SOF1. Transfer -> LENB.
//  - LENB: tx_data=LEN. Transfer -> PAY, rd_idx=0.
//  - PAY: tx_data=buf[rd_idx]. On transfer, rd_idx++; at rd_idx==LEN-1 -> CHKB.
//  - CHKB: tx_data=CHK. Transfer -> COLLECT.
//    - On CHKB exit: frm_done pulse; wr_cnt, CHK cleared; tx_vld=0; in_rdy=1 next cycle.
//  Latency
//  - Closing byte accepted at edge t -> tx_vld=1, tx_data=SOF0 after edge t+1.
//  - Next tx_data is loaded at the same edge as a transfer (no bubble beyond tx_rdy).
//  - Packet length on the wire = LEN+4 bytes.
//  Width rules
//  - wr_cnt and rd_idx are 8 bits; LEN always fits because MAX_LEN<=255.
//  - CHK is an 8-bit wrap-around add.
//  - in_vld while in_rdy=0 (during send) writes nothing and is not an error.
// TESTING
//  1. Frame 01,02,03 (last on 03), transmitter answering normally
//     -> wire AA 55 03 01 02 03 09; one frm_done; trunc=0.
//  2. Single byte FF with in_last -> AA 55 01 FF 01 (1+FF=0x100->00, +FF... CHK=(01+FF)&FF=00).
//     Required bytes: AA 55 01 FF 00.
//  3. MAX_LEN=4, source streams 10..15 with no last
//     -> AA 55 04 10 11 12 13 4A; trunc pulse once; 14,15 start next frame after frm_done.
//  4. Hold tx_rdy=0 for 100 cycles with tx_vld=1 in PAY -> tx_data and tx_vld stable; no byte
//     skipped or duplicated.
//  5. in_vld=1 with data EE throughout HDR0..CHKB -> in_rdy=0 throughout; EE not in payload; next
//     frame starts clean.
//  6. rst_n low during PAY byte 2 -> tx_vld=0 immediately; after release in_rdy=1 at the first
//     edge; next frame 07 -> AA 55 01 07 08.

Source files
------------

// File: rtl/uart_pkt_framer.sv
// uart_pkt_framer: buffers one payload frame, then sends SOF0 SOF1 LEN payload CHK over a byte handshake
module uart_pkt_framer #(
    parameter int unsigned MAX_LEN = 64,
    parameter logic [7:0]  SOF0    = 8'hAA,
    parameter logic [7:0]  SOF1    = 8'h55
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_vld,
    input  logic       in_last,
    output logic       in_rdy,
    output logic [7:0] tx_data,
    output logic       tx_vld,
    input  logic       tx_rdy,
    output logic       busy,
    output logic       frm_done,
    output logic       trunc
);
    localparam logic [2:0] COLLECT = 3'd0;
    localparam logic [2:0] HDR0    = 3'd1;
    localparam logic [2:0] HDR1    = 3'd2;
    localparam logic [2:0] LENB    = 3'd3;
    localparam logic [2:0] PAY     = 3'd4;
    localparam logic [2:0] CHKB    = 3'd5;
    localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;

    logic [2:0] state;
    logic [7:0] wr_cnt, rd_idx, chk;
    logic [7:0] mem [2**AW];
    logic [7:0] wr_nxt, rd_nxt;
    logic       in_acc, close, xfer;

    always_comb begin
        wr_nxt = wr_cnt + 8'd1;
        rd_nxt = rd_idx + 8'd1;
        in_acc = in_vld & in_rdy;
        close  = in_last | (wr_nxt == 8'(MAX_LEN));
        xfer   = tx_vld & tx_rdy;
        busy   = state != COLLECT;
    end

    always_ff @(posedge clk)
        if (in_acc)
            mem[wr_cnt[AW-1:0]] <= in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= COLLECT;
            in_rdy   <= 1'b0;
            tx_vld   <= 1'b0;
            tx_data  <= 8'h00;
            wr_cnt   <= 8'h00;
            rd_idx   <= 8'h00;
            chk      <= 8'h00;
            frm_done <= 1'b0;
            trunc    <= 1'b0;
        end else begin
            frm_done <= 1'b0;
            trunc    <= 1'b0;
            case (state)
                COLLECT: begin
                    in_rdy <= ~(in_acc & close);
                    if (in_acc) begin
                        wr_cnt <= wr_nxt;
                        chk    <= close ? chk + in_data + wr_nxt : chk + in_data;
                    end
                    if (in_acc & close) begin
                        state <= HDR0;
                        trunc <= ~in_last;
                    end
                end
                // one idle cycle after close, then SOF0 is presented
                HDR0:
                    if (!tx_vld) begin
                        tx_vld  <= 1'b1;
                        tx_data <= SOF0;
                    end else if (tx_rdy) begin
                        tx_data <= SOF1;
                        state   <= HDR1;
                    end
                HDR1:
                    if (xfer) begin
                        tx_data <= wr_cnt;
                        state   <= LENB;
                    end
                LENB:
                    if (xfer) begin
                        tx_data <= mem[{AW{1'b0}}];
                        rd_idx  <= 8'h00;
                        state   <= PAY;
                    end
                PAY:
                    if (xfer) begin
                        if (rd_idx == wr_cnt - 8'd1) begin
                            tx_data <= chk;
                            state   <= CHKB;
                        end else begin
                            tx_data <= mem[rd_nxt[AW-1:0]];
                            rd_idx  <= rd_nxt;
                        end
                    end
                CHKB:
                    if (xfer) begin
                        tx_vld   <= 1'b0;
                        in_rdy   <= 1'b1;
                        wr_cnt   <= 8'h00;
                        chk      <= 8'h00;
                        frm_done <= 1'b1;
                        state    <= COLLECT;
                    end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_pkt_framer.sv
// tb_uart_pkt_framer: table-driven frame vectors plus stall and mid-packet reset sequences, MAX_LEN=4
module tb_uart_pkt_framer;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_vld = 1'b0, in_last = 1'b0, tx_rdy = 1'b0;
    logic       in_rdy, tx_vld, busy, frm_done, trunc;
    logic [7:0] tx_data;

    always #5 clk = ~clk;

    uart_pkt_framer #(.MAX_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vld(in_vld), .in_last(in_last),
        .in_rdy(in_rdy), .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
        .busy(busy), .frm_done(frm_done), .trunc(trunc)
    );

    typedef struct {
        int          n;
        logic [47:0] d;
        int          last_idx;
        int          nw;
        logic [63:0] w;
        int          ntr;
        bit          ee;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] src_d [$];
    bit         src_l [$];
    logic [7:0] wire_q [$];
    int  errors = 0, checks = 0;
    int  done_cnt = 0, trunc_cnt = 0, stab_bad = 0, ee_bad = 0;
    bit  rdy_hold = 0, just_xfer = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input bit ee);
        logic [7:0] pd;
        bit pstall, tx_x, in_x;
        in_vld  = src_d.size() > 0 || (ee && busy);
        in_data = src_d.size() > 0 ? src_d[0] : 8'hEE;
        in_last = src_d.size() > 0 ? src_l[0] : 1'b0;
        if (ee && busy && in_rdy) ee_bad++;
        tx_rdy = !rdy_hold && !just_xfer;
        in_x   = in_vld && in_rdy;
        tx_x   = tx_vld && tx_rdy;
        pd     = tx_data;
        pstall = tx_vld && !tx_rdy;
        if (tx_x) wire_q.push_back(tx_data);
        if (in_x && src_d.size() > 0) begin
            void'(src_d.pop_front());
            void'(src_l.pop_front());
        end
        @(posedge clk);
        #1;
        just_xfer = tx_x;
        if (frm_done) done_cnt++;
        if (trunc) trunc_cnt++;
        if (pstall && (!tx_vld || tx_data !== pd)) stab_bad++;
    endtask

    task automatic push_frame(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            src_d.push_back(v.d[47-8*i -: 8]);
            src_l.push_back(i == v.last_idx);
        end
    endtask

    task automatic step_until_wire(input int n, input int budget);
        for (int i = 0; i < budget && wire_q.size() < n; i++) step(1'b0);
    endtask

    task automatic finish_frame(input bit ee);
        for (int i = 0; i < 300 && done_cnt == 0; i++) step(ee);
        step(ee);
        step(ee);
        chk("frm_done_count", done_cnt, 1);
    endtask

    task automatic check_wire(input string nm, input int nw, input logic [63:0] w);
        chk({nm, "_len"}, wire_q.size(), nw);
        for (int i = 0; i < nw && i < wire_q.size(); i++)
            chk($sformatf("%s_byte%0d", nm, i), wire_q[i], w[63-8*i -: 8]);
    endtask

    initial begin
        vecs[0] = '{3, 48'h01_02_03_00_00_00, 2,  7, 64'hAA_55_03_01_02_03_09_00, 0, 0};
        vecs[1] = '{1, 48'hFF_00_00_00_00_00, 0,  5, 64'hAA_55_01_FF_00_00_00_00, 0, 0};
        vecs[2] = '{6, 48'h10_11_12_13_14_15, -1, 8, 64'hAA_55_04_10_11_12_13_4A, 1, 0};
        vecs[3] = '{1, 48'h16_00_00_00_00_00, 0,  7, 64'hAA_55_03_14_15_16_42_00, 0, 0};
        vecs[4] = '{2, 48'h21_22_00_00_00_00, 1,  6, 64'hAA_55_02_21_22_45_00_00, 0, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_tx_vld", tx_vld, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_frm_done", frm_done, 0);
        chk("rst_trunc", trunc, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_rdy_after_release", in_rdy, 1);

        for (int v = 0; v < 5; v++) begin
            wire_q.delete();
            done_cnt = 0;
            trunc_cnt = 0;
            ee_bad = 0;
            push_frame(vecs[v]);
            finish_frame(vecs[v].ee);
            check_wire($sformatf("vec%0d", v), vecs[v].nw, vecs[v].w);
            chk($sformatf("vec%0d_trunc", v), trunc_cnt, vecs[v].ntr);
            if (vecs[v].ee) chk("ee_in_rdy_low", ee_bad, 0);
        end

        // long transmitter stall while a payload byte is presented
        wire_q.delete();
        done_cnt = 0;
        push_frame('{3, 48'h31_32_33_00_00_00, 2, 0, 64'h0, 0, 0});
        step_until_wire(4, 100);
        rdy_hold = 1;
        step(1'b0);
        chk("stall_tx_vld", tx_vld, 1);
        chk("stall_tx_data", tx_data, 8'h32);
        repeat (100) step(1'b0);
        chk("stall_hold_vld", tx_vld, 1);
        chk("stall_hold_data", tx_data, 8'h32);
        chk("stall_no_transfer", wire_q.size(), 4);
        rdy_hold = 0;
        finish_frame(1'b0);
        check_wire("stall", 7, 64'hAA_55_03_31_32_33_99_00);
        chk("tx_stable", stab_bad, 0);

        // reset while the second payload byte waits
        wire_q.delete();
        push_frame('{3, 48'h41_42_43_00_00_00, 2, 0, 64'h0, 0, 0});
        step_until_wire(4, 100);
        chk("pre_rst_tx_vld", tx_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx_vld", tx_vld, 0);
        chk("rst_async_busy", busy, 0);
        src_d.delete();
        src_l.delete();
        in_vld = 1'b0;
        tx_rdy = 1'b0;
        just_xfer = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_rdy_after_midrst", in_rdy, 1);
        wire_q.delete();
        done_cnt = 0;
        push_frame('{1, 48'h07_00_00_00_00_00, 0, 0, 64'h0, 0, 0});
        finish_frame(1'b0);
        check_wire("post_rst", 5, 64'hAA_55_01_07_08_00_00_00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
